// File: rtl/mux_serializer_ctrl.sv
// -----------------------------------------------------------------------------
// mux_serializer_ctrl
//
// Parallel-to-serial controller for an external combinational 16:1 mux.
// A word plus length is accepted over a valid/ready handshake and parked on
// the mux data inputs. The mux select is then stepped one index per accepted
// output beat, and the mux output is forwarded as a framed serial stream.
//
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   i_in_valid     : word offered
//   o_in_ready     : word can be accepted this cycle
//   i_in_data      : word to serialize
//   i_in_len       : number of bits to send minus one
//   o_mux_in       : registered word, drives the mux data inputs
//   o_mux_select   : registered index, drives the mux select
//   i_mux_w        : mux output
//   o_sout_valid   : serial bit valid
//   o_sout_bit     : serial bit (pass-through of i_mux_w)
//   o_sout_last    : current bit is the final bit of the word
//   i_sout_ready   : downstream accepts the bit
//   o_busy         : a word is being shifted out
// -----------------------------------------------------------------------------
module mux_serializer_ctrl #(
    parameter int WIDTH     = 16,
    parameter int SEL_W     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic [SEL_W-1:0] i_in_len,
    output logic [WIDTH-1:0] o_mux_in,
    output logic [SEL_W-1:0] o_mux_select,
    input  logic             i_mux_w,
    output logic             o_sout_valid,
    output logic             o_sout_bit,
    output logic             o_sout_last,
    input  logic             i_sout_ready,
    output logic             o_busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_mux_in;
    logic [WIDTH-1:0]   w_mux_in_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [SEL_W-1:0]   r_len;
    logic [SEL_W-1:0]   w_len_nxt;

    logic [SEL_W-1:0]   w_end_idx;
    logic [SEL_W-1:0]   w_start_idx;
    logic               w_shift;
    logic               w_at_end;
    logic               w_beat;
    logic               w_load;

    // Shift direction fixes where a word starts and where it ends.
    assign w_end_idx   = MSB_FIRST ? {SEL_W{1'b0}} : r_len;
    assign w_start_idx = MSB_FIRST ? i_in_len : {SEL_W{1'b0}};

    assign w_shift  = (r_state == ST_SHIFT);
    assign w_at_end = (r_sel == w_end_idx);
    assign w_beat   = w_shift & i_sout_ready;

    // Accepting on the final beat lets the next word start with no bubble.
    assign o_in_ready = ~w_shift | (w_at_end & i_sout_ready);
    assign w_load     = i_in_valid & o_in_ready;

    assign o_mux_in     = r_mux_in;
    assign o_mux_select = r_sel;
    assign o_sout_valid = w_shift;
    assign o_sout_last  = w_shift & w_at_end;
    assign o_sout_bit   = i_mux_w;
    assign o_busy       = w_shift;

    // Next-state, next-word and next-index selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_mux_in_nxt = r_mux_in;
        w_sel_nxt    = r_sel;
        w_len_nxt    = r_len;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_mux_in_nxt = i_in_data;
                    w_len_nxt    = i_in_len;
                    w_sel_nxt    = w_start_idx;
                    w_state_nxt  = ST_SHIFT;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_beat) begin
                    if (w_at_end) begin
                        if (w_load) begin
                            w_mux_in_nxt = i_in_data;
                            w_len_nxt    = i_in_len;
                            w_sel_nxt    = w_start_idx;
                            w_state_nxt  = ST_SHIFT;
                        end else begin
                            // Word and index are held so the mux output stays quiet.
                            w_state_nxt  = ST_IDLE;
                        end
                    end else begin
                        // Counter stops at the end index, so this never wraps.
                        if (MSB_FIRST) begin
                            w_sel_nxt = r_sel - SEL_W'(1);
                        end else begin
                            w_sel_nxt = r_sel + SEL_W'(1);
                        end
                    end
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, word, index and length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mux_in <= {WIDTH{1'b0}};
            r_sel    <= {SEL_W{1'b0}};
            r_len    <= {SEL_W{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_mux_in <= w_mux_in_nxt;
            r_sel    <= w_sel_nxt;
            r_len    <= w_len_nxt;
        end
    end

endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_serializer_ctrl
//
// Drives an LSB-first and an MSB-first instance with identical stimulus and
// compares both against a beat-queue reference: every accepted word is
// expanded into its list of expected beats (bit, select, last) up front.
// -----------------------------------------------------------------------------
module tb_mux_serializer_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_len;
    logic        sout_ready;

    logic        ready_l, ready_m;
    logic [15:0] mux_in_l, mux_in_m;
    logic [3:0]  sel_l, sel_m;
    logic        w_l, w_m;
    logic        valid_l, valid_m;
    logic        bit_l, bit_m;
    logic        last_l, last_m;
    logic        busy_l, busy_m;

    // External mux models.
    assign w_l = mux_in_l[sel_l];
    assign w_m = mux_in_m[sel_m];

    mux_serializer_ctrl #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(ready_l),
        .i_in_data(in_data), .i_in_len(in_len),
        .o_mux_in(mux_in_l), .o_mux_select(sel_l), .i_mux_w(w_l),
        .o_sout_valid(valid_l), .o_sout_bit(bit_l), .o_sout_last(last_l),
        .i_sout_ready(sout_ready), .o_busy(busy_l)
    );

    mux_serializer_ctrl #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(ready_m),
        .i_in_data(in_data), .i_in_len(in_len),
        .o_mux_in(mux_in_m), .o_mux_select(sel_m), .i_mux_w(w_m),
        .o_sout_valid(valid_m), .o_sout_bit(bit_m), .o_sout_last(last_m),
        .i_sout_ready(sout_ready), .o_busy(busy_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] word;
        logic        b_l;
        logic [3:0]  s_l;
        logic        b_m;
        logic [3:0]  s_m;
        logic        last;
    } beat_t;

    beat_t       q[$];
    logic [15:0] hold_word;
    logic [3:0]  hold_sel_l;
    logic [3:0]  hold_sel_m;
    logic        acc;
    int          n_cmp;
    int          n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expand a word into its beat list for both shift directions.
    task automatic model_push(input logic [15:0] d, input logic [3:0] l);
        beat_t e;
        for (int k = 0; k <= int'(l); k++) begin
            e.word = d;
            e.s_l  = 4'(k);
            e.b_l  = d[k];
            e.s_m  = 4'(int'(l) - k);
            e.b_m  = d[int'(l) - k];
            e.last = (k == int'(l));
            q.push_back(e);
        end
    endtask

    task automatic model_reset();
        q.delete();
        hold_word  = 16'h0000;
        hold_sel_l = 4'd0;
        hold_sel_m = 4'd0;
    endtask

    task automatic check_outputs();
        logic exp_valid;
        logic exp_ready;
        exp_valid = (q.size() != 0);
        exp_ready = !exp_valid || (q[0].last && sout_ready);
        check_eq("valid_l", 32'(valid_l), 32'(exp_valid));
        check_eq("valid_m", 32'(valid_m), 32'(exp_valid));
        check_eq("busy_l",  32'(busy_l),  32'(exp_valid));
        check_eq("busy_m",  32'(busy_m),  32'(exp_valid));
        check_eq("ready_l", 32'(ready_l), 32'(exp_ready));
        check_eq("ready_m", 32'(ready_m), 32'(exp_ready));
        if (exp_valid) begin
            check_eq("bit_l",    32'(bit_l),    32'(q[0].b_l));
            check_eq("bit_m",    32'(bit_m),    32'(q[0].b_m));
            check_eq("sel_l",    32'(sel_l),    32'(q[0].s_l));
            check_eq("sel_m",    32'(sel_m),    32'(q[0].s_m));
            check_eq("last_l",   32'(last_l),   32'(q[0].last));
            check_eq("last_m",   32'(last_m),   32'(q[0].last));
            check_eq("muxin_l",  32'(mux_in_l), 32'(q[0].word));
            check_eq("muxin_m",  32'(mux_in_m), 32'(q[0].word));
        end else begin
            check_eq("idle_last_l", 32'(last_l),   32'd0);
            check_eq("idle_last_m", 32'(last_m),   32'd0);
            check_eq("idle_sel_l",  32'(sel_l),    32'(hold_sel_l));
            check_eq("idle_sel_m",  32'(sel_m),    32'(hold_sel_m));
            check_eq("idle_muxin_l", 32'(mux_in_l), 32'(hold_word));
            check_eq("idle_muxin_m", 32'(mux_in_m), 32'(hold_word));
        end
    endtask

    // One clock: check away from the edge, then advance the model on the edge.
    task automatic cycle();
        logic  m_ready;
        beat_t e;
        @(negedge clk);
        if (!rst_n) model_reset();
        check_outputs();
        @(posedge clk);
        acc = 1'b0;
        if (rst_n) begin
            m_ready = (q.size() == 0) || (q[0].last && sout_ready);
            acc     = in_valid && m_ready;
            if ((q.size() != 0) && sout_ready) begin
                e          = q.pop_front();
                hold_sel_l = e.s_l;
                hold_sel_m = e.s_m;
            end
            if (acc) begin
                model_push(in_data, in_len);
                hold_word = in_data;
            end
        end
        #1;
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] l, input logic hold);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
        n        = 0;
        acc      = 1'b0;
        while (!acc && n < 100) begin
            cycle();
            n++;
        end
        if (!acc) check_eq("offer_timeout", 32'd0, 32'd1);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [6:0] bp_pat;
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 16'h0000;
        in_len     = 4'd0;
        sout_ready = 1'b1;
        model_reset();

        // Reset values while held in reset, then after release.
        run(2);
        rst_n = 1'b1;
        run(1);

        // LSB/MSB full word.
        offer(16'h8001, 4'd15, 1'b0);
        run(18);

        // 8-bit word, both directions.
        offer(16'h00F0, 4'd7, 1'b0);
        run(10);

        // Backpressure pattern 1,0,0,1,1,0,1.
        bp_pat = 7'b1011001;
        offer(16'h0005, 4'd3, 1'b0);
        for (int i = 0; i < 7; i++) begin
            sout_ready = bp_pat[i];
            cycle();
        end
        sout_ready = 1'b1;
        run(4);

        // Back-to-back words with valid held.
        offer(16'h0003, 4'd1, 1'b1);
        offer(16'h0002, 4'd1, 1'b0);
        run(4);

        // Single bit word.
        offer(16'hFFFE, 4'd0, 1'b0);
        run(3);

        // Reset mid-word, then a fresh word.
        offer(16'hA5A5, 4'd15, 1'b0);
        run(5);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        offer(16'h1234, 4'd3, 1'b0);
        run(6);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            in_valid   = ($urandom_range(0, 2) != 0);
            in_data    = 16'($urandom);
            in_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            sout_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid   = 1'b0;
        sout_ready = 1'b1;
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
